// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encoding and grant constants for mem_arbiter
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ_IF = 3'd1,
        REQ_LS = 3'd2,
        RSP_IF = 3'd3,
        RSP_LS = 3'd4
    } arb_state_t;

    localparam logic GRANT_IF = 1'b0;
    localparam logic GRANT_LS = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - IF/LS requester and memory-port bundle around mem_arbiter
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
);
    logic                  if_req_valid;
    logic                  if_req_ready;
    logic [ADDR_W-1:0]     if_req_addr;
    logic [LEN_W-1:0]      if_req_len;
    logic                  if_rsp_valid;
    logic [DATA_W-1:0]     if_rsp_data;
    logic                  if_rsp_last;

    logic                  ls_req_valid;
    logic                  ls_req_ready;
    logic [ADDR_W-1:0]     ls_req_addr;
    logic                  ls_req_wen;
    logic [DATA_W-1:0]     ls_req_wdata;
    logic [DATA_W/8-1:0]   ls_req_wmask;
    logic                  ls_rsp_valid;
    logic [DATA_W-1:0]     ls_rsp_rdata;

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_W-1:0]     mem_req_addr;
    logic                  mem_req_wen;
    logic [DATA_W-1:0]     mem_req_wdata;
    logic [DATA_W/8-1:0]   mem_req_wmask;
    logic [LEN_W-1:0]      mem_req_len;
    logic                  mem_rsp_valid;
    logic [DATA_W-1:0]     mem_rsp_data;
    logic                  mem_rsp_last;

    // Arbiter side: requesters come in, memory port goes out.
    modport slave (
        input  if_req_valid, if_req_addr, if_req_len,
        output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_last,
        input  ls_req_valid, ls_req_addr, ls_req_wen, ls_req_wdata, ls_req_wmask,
        output ls_req_ready, ls_rsp_valid, ls_rsp_rdata,
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask, mem_req_len,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_last
    );

    modport master (
        output if_req_valid, if_req_addr, if_req_len,
        input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_last,
        output ls_req_valid, ls_req_addr, ls_req_wen, ls_req_wdata, ls_req_wmask,
        input  ls_req_ready, ls_rsp_valid, ls_rsp_rdata,
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask, mem_req_len,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_last
    );
endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - 32-bit saturating event counter with synchronous clear
module sat_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    input  logic        clr,
    output logic [31:0] count
);
    logic [31:0] count_q;
    logic [31:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != 32'hFFFF_FFFF)) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - IF/LS arbiter holding the shared memory port until the response completes
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic               clk,
    input  logic               reset,
    mem_arbiter_if.slave       bus,
    input  logic               cnt_clr,
    output logic [31:0]        cnt_if_grant,
    output logic [31:0]        cnt_ls_grant,
    output logic [31:0]        cnt_if_wait,
    output logic [31:0]        cnt_ls_wait
);
    arb_state_t            state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  wen_q, wen_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W/8-1:0]   wmask_q, wmask_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic                  mem_req_valid_q, mem_req_valid_d;
    logic                  grant;
    logic                  if_hs;
    logic                  ls_hs;

    // On a conflict the requester that did not win last time goes next.
    always_comb begin
        if (bus.if_req_valid && bus.ls_req_valid) begin
            grant = ~last_grant_q;
        end else if (bus.ls_req_valid) begin
            grant = GRANT_LS;
        end else begin
            grant = GRANT_IF;
        end
    end

    assign bus.if_req_ready = (state_q == IDLE) && (grant == GRANT_IF);
    assign bus.ls_req_ready = (state_q == IDLE) && (grant == GRANT_LS);
    assign if_hs = bus.if_req_valid && bus.if_req_ready;
    assign ls_hs = bus.ls_req_valid && bus.ls_req_ready;

    always_comb begin
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        addr_d          = addr_q;
        wen_d           = wen_q;
        wdata_d         = wdata_q;
        wmask_d         = wmask_q;
        len_d           = len_q;
        mem_req_valid_d = mem_req_valid_q;
        case (state_q)
            IDLE: begin
                if (if_hs) begin
                    state_d         = REQ_IF;
                    last_grant_d    = GRANT_IF;
                    addr_d          = bus.if_req_addr;
                    wen_d           = 1'b0;
                    wdata_d         = '0;
                    wmask_d         = '0;
                    len_d           = bus.if_req_len;
                    mem_req_valid_d = 1'b1;
                end else if (ls_hs) begin
                    state_d         = REQ_LS;
                    last_grant_d    = GRANT_LS;
                    addr_d          = bus.ls_req_addr;
                    wen_d           = bus.ls_req_wen;
                    wdata_d         = bus.ls_req_wdata;
                    wmask_d         = bus.ls_req_wmask;
                    len_d           = '0;
                    mem_req_valid_d = 1'b1;
                end
            end
            REQ_IF: begin
                if (bus.mem_req_ready) begin
                    state_d         = RSP_IF;
                    mem_req_valid_d = 1'b0;
                end
            end
            REQ_LS: begin
                if (bus.mem_req_ready) begin
                    state_d         = RSP_LS;
                    mem_req_valid_d = 1'b0;
                end
            end
            RSP_IF: begin
                if (bus.mem_rsp_valid && bus.mem_rsp_last) state_d = IDLE;
            end
            RSP_LS: begin
                // A single-word access completes on its first beat whatever last says.
                if (bus.mem_rsp_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            last_grant_q    <= GRANT_IF;
            addr_q          <= '0;
            wen_q           <= 1'b0;
            wdata_q         <= '0;
            wmask_q         <= '0;
            len_q           <= '0;
            mem_req_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            last_grant_q    <= last_grant_d;
            addr_q          <= addr_d;
            wen_q           <= wen_d;
            wdata_q         <= wdata_d;
            wmask_q         <= wmask_d;
            len_q           <= len_d;
            mem_req_valid_q <= mem_req_valid_d;
        end
    end

    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_req_addr  = addr_q;
    assign bus.mem_req_wen   = wen_q;
    assign bus.mem_req_wdata = wdata_q;
    assign bus.mem_req_wmask = wmask_q;
    assign bus.mem_req_len   = len_q;

    assign bus.if_rsp_valid  = (state_q == RSP_IF) && bus.mem_rsp_valid;
    assign bus.if_rsp_last   = bus.mem_rsp_last;
    assign bus.if_rsp_data   = bus.mem_rsp_data;
    assign bus.ls_rsp_valid  = (state_q == RSP_LS) && bus.mem_rsp_valid;
    assign bus.ls_rsp_rdata  = bus.mem_rsp_data;

    sat_counter u_cnt_if_grant (.clk(clk), .reset(reset), .inc(if_hs), .clr(cnt_clr), .count(cnt_if_grant));
    sat_counter u_cnt_ls_grant (.clk(clk), .reset(reset), .inc(ls_hs), .clr(cnt_clr), .count(cnt_ls_grant));
    sat_counter u_cnt_if_wait (
        .clk(clk), .reset(reset), .inc(bus.if_req_valid && !bus.if_req_ready), .clr(cnt_clr), .count(cnt_if_wait)
    );
    sat_counter u_cnt_ls_wait (
        .clk(clk), .reset(reset), .inc(bus.ls_req_valid && !bus.ls_req_ready), .clr(cnt_clr), .count(cnt_ls_wait)
    );
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester memory-port arbiter and sequencer between the ICache refill path (IF) and the LSU (LS), which share the single core memory port. It grants one requester at a time and holds the grant until that transaction's response completes. It counts grants and stall cycles so the performance model can read memory contention directly in hardware. It sits between the ICache/LSU and the core's memory bridge.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- LEN_W, 4, burst length field width (beats minus 1)
- clk  in  1  clock; everything is on the rising edge
- reset  in  1  asynchronous, active-low (0 = in reset)
- if_req_valid / if_req_ready  in / out  1  IF request handshake
- if_req_addr  in  ADDR_W  IF refill address
- if_req_len  in  LEN_W  IF burst beats minus 1
- if_rsp_valid  out  1  IF response beat valid
- if_rsp_data  out  DATA_W  IF response beat data
- if_rsp_last  out  1  IF final response beat
- ls_req_valid / ls_req_ready  in / out  1  LS request handshake
- ls_req_addr  in  ADDR_W  LS address
- ls_req_wen  in  1  LS write enable (1 = write)
- ls_req_wdata  in  DATA_W  LS write data
- ls_req_wmask  in  DATA_W/8  LS byte mask
- ls_rsp_valid  out  1  LS response valid (read data or write ack)
- ls_rsp_rdata  out  DATA_W  LS read data
- mem_req_valid / mem_req_ready  out / in  1  memory request handshake
- mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask, mem_req_len  out  as above  latched request fields
- mem_rsp_valid  in  1  memory response beat valid
- mem_rsp_data  in  DATA_W  memory response beat data
- mem_rsp_last  in  1  memory final response beat
- cnt_clr  in  1  synchronous clear of all counters
- cnt_if_grant, cnt_ls_grant, cnt_if_wait, cnt_ls_wait  out  32  performance counters

## Operation
- FSM states and transitions:
  - IDLE → REQ_IF or REQ_LS on a grant.
  - REQ_x → RSP_x on mem_req_valid && mem_req_ready.
  - RSP_IF → IDLE on mem_rsp_valid && mem_rsp_last.
  - RSP_LS → IDLE on the first mem_rsp_valid (mem_rsp_last is ignored).
- Grant, evaluated only in IDLE:
  - Only one requester valid: grant it.
  - Both valid: grant the one not in last_grant.
  - last_grant resets to IF, so the first conflict goes to LS.
- Ready signals: x_req_ready = (state==IDLE) && grant==x, combinational. Request fields are latched into registers on the handshake. last_grant is updated at the same edge.
- IF request latch: mem_req_wen=0, wmask=0, mem_req_len=if_req_len.
- LS request latch: mem_req_len=0.
- Responses pass through combinationally:
  - if_rsp_valid = (state==RSP_IF) && mem_rsp_valid.
  - if_rsp_last = mem_rsp_last.
  - ls_rsp_valid = (state==RSP_LS) && mem_rsp_valid.
  - Data is wired straight from mem_rsp_data.
- mem_rsp_valid in IDLE or REQ_x is dropped and not forwarded.
- Requesters accept every response beat; there is no response back-pressure.
- Counters (32-bit, saturate at 0xFFFF_FFFF):
  - cnt_x_grant increments on x_req handshake.
  - cnt_x_wait increments each cycle with x_req_valid && !x_req_ready.
  - cnt_clr takes priority over increment.

## Timing
- Reset values (async assert, sync deassert by the upstream reset synchroniser):
  - state=IDLE, last_grant=IF.
  - All latched request fields 0.
  - mem_req_valid=0.
  - All rsp valids 0.
  - All counters 0.
- Reset asserted mid-transaction aborts it immediately. Nothing is replayed.
- Latency:
  - Requester handshake at cycle T → mem_req_valid=1 at T+1.
  - mem_req_valid is held, with fields stable, until mem_req_ready.
- Response beats: zero added latency.
- Back-to-back: last response beat at cycle T → state IDLE at T+1, where the next grant/handshake may occur. mem_req_valid at T+2.
- mem_req_valid and mem_req_ready both 1 in the same cycle as the state enters REQ_x cannot occur; mem_req_valid is registered.

## Structure
- Package mem_arb_pkg holds:
  - enum arb_state_t {IDLE, REQ_IF, REQ_LS, RSP_IF, RSP_LS}.
  - Constants GRANT_IF=1'b0, GRANT_LS=1'b1.
- Sub-module sat_counter (32-bit; inc, clr inputs; saturating), instantiated four times.

## Test plan
- Reset, then IF req addr 0x8000_0000 len 3, memory ready at once, 4 beats D0..D3 with last on D3 → if_rsp_valid on exactly 4 cycles, if_rsp_last only on D3, cnt_if_grant=1, back to IDLE.
- IF and LS both valid in the same IDLE cycle, held valid → grants in order LS, IF, LS. cnt_if_wait counts every cycle IF was held off.
- LS write addr 0x1000, wdata 0xDEADBEEF, wmask 0xF, mem_req_ready delayed 3 cycles → mem_req fields stable for all 4 valid cycles, mem_req_len=0, single ls_rsp_valid.
- mem_rsp_valid pulsed while in IDLE and in REQ_LS → no if/ls rsp_valid.
- reset asserted during RSP_IF beat 2 of 4 → next cycle all outputs at reset values. After release, a new LS request is granted normally.
- Force cnt_ls_wait to 0xFFFF_FFFE, then 3 wait cycles → holds at 0xFFFF_FFFF. cnt_clr → 0 next cycle.
